// File: rtl/muldiv_iter_pkg.sv
// Shared definitions for the multiply/divide unit. The hazard unit imports
// the op codes from here as well.
package muldiv_iter_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam logic HILO_SEL_LO = 1'b0;
    localparam logic HILO_SEL_HI = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL      = 2'd1,
        ST_DIV_ITER = 2'd2,
        ST_DIV_FIX  = 2'd3
    } md_state_e;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_MUL  = 2'd1,
        CLS_DIV  = 2'd2
    } op_class_e;

    // Which engine (if any) an op code occupies.
    function automatic op_class_e op_class(input logic [3:0] op);
        op_class_e cls;
        cls = CLS_NONE;
        case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: cls = CLS_MUL;
            OP_DIV, OP_DIVU:                                         cls = CLS_DIV;
            default:                                                 cls = CLS_NONE;
        endcase
        return cls;
    endfunction

    // Signed flavour of a multiply/divide op.
    function automatic logic op_is_signed(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/muldiv_iter_div_radix2.sv
// Magnitude-only restoring divider, one quotient bit per step.
// Signs and the iteration count are handled by the parent.
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Trial subtraction; the extra top bit of diff is the borrow.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
    end

    // Dividend bits shift out of quo_q while quotient bits shift in.
    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (step) begin
            if (diff[WIDTH]) begin
                rem_q <= shifted[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end else begin
                rem_q <= diff[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    assign q = quo_q;
    assign r = rem_q;

endmodule

// File: rtl/muldiv_iter.sv
// Multiply/divide unit with HI/LO registers, sitting beside the EX-stage ALU.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | no op in flight; accepts start, performs MTHI/MTLO
// ST_MUL      | multiply latency timer counting down to terminal count 0
// ST_DIV_ITER | one restoring divide step per cycle, WIDTH steps
// ST_DIV_FIX  | apply quotient/remainder signs and commit
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hilo_sel,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(((WIDTH > MUL_LAT) ? WIDTH : MUL_LAT) + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
    logic               done_q;
    logic               accept, commit, div_load, div_step, mt_write;

    logic               sgn_q;
    logic [2*WIDTH-1:0] a_ext, b_ext, product, mul_res;
    logic [WIDTH-1:0]   a_mag, b_mag, div_q, div_r, quo_fix, rem_fix;

    // Next state, down-counter and per-cycle strobes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        commit   = 1'b0;
        div_load = 1'b0;
        div_step = 1'b0;
        mt_write = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    case (op_class(op))
                        CLS_MUL: begin
                            accept  = 1'b1;
                            state_d = ST_MUL;
                            cnt_d   = CNT_W'(MUL_LAT - 1);
                        end
                        CLS_DIV: begin
                            accept   = 1'b1;
                            div_load = 1'b1;
                            state_d  = ST_DIV_ITER;
                            cnt_d    = CNT_W'(WIDTH - 1);
                        end
                        default: mt_write = (op == OP_MTHI) || (op == OP_MTLO);
                    endcase
                end
            end
            ST_MUL: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DIV_ITER: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    div_step = 1'b1;
                    if (cnt_q == '0) state_d = ST_DIV_FIX;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            ST_DIV_FIX: begin
                state_d = ST_IDLE;
                commit  = !cancel;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Product of the latched operands and the accumulate variants, all modulo 2^(2W).
    always_comb begin
        sgn_q   = op_is_signed(op_q);
        a_ext   = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext   = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        product = a_ext * b_ext;
        case (op_q)
            OP_MADD, OP_MADDU: mul_res = {hi_q, lo_q} + product;
            OP_MSUB, OP_MSUBU: mul_res = {hi_q, lo_q} - product;
            default:           mul_res = product;
        endcase
    end

    // Magnitudes go into the divider at accept; signs come back from the latched operands.
    always_comb begin
        a_mag   = (op == OP_DIV && a[WIDTH-1]) ? -a : a;
        b_mag   = (op == OP_DIV && b[WIDTH-1]) ? -b : b;
        quo_fix = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -div_q : div_q;
        rem_fix = (sgn_q && a_q[WIDTH-1]) ? -div_r : div_r;
    end

    div_radix2 #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load),
        .step     (div_step),
        .dividend (a_mag),
        .divisor  (b_mag),
        .q        (div_q),
        .r        (div_r)
    );

    // State, operand latches and the HI/LO architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= commit;
            if (accept) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
            end
            if (mt_write) begin
                if (op == OP_MTHI) hi_q <= a;
                else               lo_q <= a;
            end
            if (commit) begin
                if (state_q == ST_MUL) begin
                    {hi_q, lo_q} <= mul_res;
                end else if (b_q != '0) begin
                    lo_q <= quo_fix;
                    hi_q <= rem_fix;
                end
            end
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign out  = (hilo_sel == HILO_SEL_HI) ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: a 32-bit/MUL_LAT=5 instance and a 16-bit/MUL_LAT=1
// instance, both checked against an arithmetic model of HI/LO.
module tb_muldiv_iter;
    import muldiv_iter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  start_v;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        cancel, hilo_sel;
    logic [31:0] out32;
    logic [15:0] out16;
    logic        busy32, busy16, done32, done16;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi [2];
    logic [31:0] m_lo [2];

    always #5 clk = ~clk;

    muldiv_iter #(.WIDTH(32), .MUL_LAT(5)) dut32 (
        .clk(clk), .reset(reset), .start(start_v[0]), .op(op), .a(a), .b(b),
        .cancel(cancel), .hilo_sel(hilo_sel), .out(out32), .busy(busy32), .done(done32)
    );

    muldiv_iter #(.WIDTH(16), .MUL_LAT(1)) dut16 (
        .clk(clk), .reset(reset), .start(start_v[1]), .op(op), .a(a[15:0]), .b(b[15:0]),
        .cancel(cancel), .hilo_sel(hilo_sel), .out(out16), .busy(busy16), .done(done16)
    );

    function automatic logic [31:0] wmask(input int s);
        return (s == 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic busy_of(input int s);
        return (s == 1) ? busy16 : busy32;
    endfunction

    function automatic logic done_of(input int s);
        return (s == 1) ? done16 : done32;
    endfunction

    task automatic read_reg(input int s, input logic sel, output logic [31:0] v);
        hilo_sel = sel;
        #1;
        v = (s == 1) ? {16'h0, out16} : out32;
    endtask

    // Reference: plain integer arithmetic on {HI,LO}; returns expected busy cycles.
    function automatic int model_apply(input int s, input logic [3:0] o,
                                       input logic [31:0] x, input logic [31:0] y);
        int          w;
        logic [63:0] m2, acc;
        logic [31:0] m1;
        longint      sx, sy, ux, uy, q, r;
        int          lat;
        w   = (s == 1) ? 16 : 32;
        m1  = wmask(s);
        m2  = (s == 1) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        sx  = (s == 1) ? longint'($signed(x[15:0])) : longint'($signed(x));
        sy  = (s == 1) ? longint'($signed(y[15:0])) : longint'($signed(y));
        ux  = longint'(x & m1);
        uy  = longint'(y & m1);
        acc = ({32'h0, m_hi[s]} << w) | {32'h0, m_lo[s]};
        lat = 0;
        case (o)
            OP_MULT:  begin acc = sx * sy;       lat = (s == 1) ? 1 : 5; end
            OP_MULTU: begin acc = ux * uy;       lat = (s == 1) ? 1 : 5; end
            OP_MADD:  begin acc = acc + sx * sy; lat = (s == 1) ? 1 : 5; end
            OP_MADDU: begin acc = acc + ux * uy; lat = (s == 1) ? 1 : 5; end
            OP_MSUB:  begin acc = acc - sx * sy; lat = (s == 1) ? 1 : 5; end
            OP_MSUBU: begin acc = acc - ux * uy; lat = (s == 1) ? 1 : 5; end
            default: ;
        endcase
        if (lat != 0) begin
            acc     = acc & m2;
            m_hi[s] = 32'(acc >> w) & m1;
            m_lo[s] = 32'(acc) & m1;
        end
        if (o == OP_DIV || o == OP_DIVU) begin
            lat = w + 1;
            if (o == OP_DIV) begin q = (sy != 0) ? sx / sy : 0; r = (sy != 0) ? sx % sy : 0; end
            else             begin q = (uy != 0) ? ux / uy : 0; r = (uy != 0) ? ux % uy : 0; end
            if (uy != 0) begin
                m_lo[s] = 32'(q) & m1;
                m_hi[s] = 32'(r) & m1;
            end
        end
        if (o == OP_MTHI) m_hi[s] = x & m1;
        if (o == OP_MTLO) m_lo[s] = x & m1;
        return lat;
    endfunction

    task automatic issue(input int s, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start_v[s] = 1'b1;
        @(posedge clk); #1;
        start_v[s] = 1'b0;
    endtask

    task automatic check_hilo(input int s, input string tag);
        logic [31:0] vh, vl;
        read_reg(s, 1'b1, vh);
        read_reg(s, 1'b0, vl);
        checks++;
        if (vh !== m_hi[s]) begin errors++; $display("FAIL %s w%0d hi: got %h want %h", tag, s, vh, m_hi[s]); end
        checks++;
        if (vl !== m_lo[s]) begin errors++; $display("FAIL %s w%0d lo: got %h want %h", tag, s, vl, m_lo[s]); end
    endtask

    // Issue one op and follow it to the end, checking latency, done and HI/LO.
    task automatic do_op(input int s, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input string tag);
        int          exp_lat, n;
        logic [31:0] old_lo, v;
        old_lo  = m_lo[s];
        exp_lat = model_apply(s, o, x, y);
        issue(s, o, x, y);
        n = 0;
        while (busy_of(s) && n < 200) begin
            n++;
            if (n == 1) begin
                read_reg(s, 1'b0, v);
                checks++;
                if (v !== old_lo) begin errors++; $display("FAIL %s w%0d old_lo: got %h want %h", tag, s, v, old_lo); end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (n != exp_lat) begin errors++; $display("FAIL %s w%0d latency: got %0d want %0d", tag, s, n, exp_lat); end
        checks++;
        if (done_of(s) !== (exp_lat > 0)) begin errors++; $display("FAIL %s w%0d done: got %b want %b", tag, s, done_of(s), exp_lat > 0); end
        check_hilo(s, tag);
    endtask

    task automatic expect_val(input int s, input logic sel, input logic [31:0] want, input string tag);
        logic [31:0] v;
        read_reg(s, sel, v);
        checks++;
        if (v !== (want & wmask(s))) begin errors++; $display("FAIL %s w%0d: got %h want %h", tag, s, v, want & wmask(s)); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            m_hi[s] = '0; m_lo[s] = '0;
            checks++;
            if (busy_of(s) !== 1'b0 || done_of(s) !== 1'b0) begin
                errors++; $display("FAIL reset w%0d busy/done: got %b%b want 00", s, busy_of(s), done_of(s));
            end
            check_hilo(s, "reset");
        end
    endtask

    task automatic test_mult();
        for (int s = 0; s < 2; s++) begin
            do_op(s, OP_MULT, -32'sd3, 32'd7, "mult");
            expect_val(s, 1'b0, 32'hFFFF_FFEB, "mult_lo");
            expect_val(s, 1'b1, 32'hFFFF_FFFF, "mult_hi");
            @(posedge clk); #1;
            checks++;
            if (done_of(s) !== 1'b0) begin errors++; $display("FAIL done_pulse w%0d: got %b want 0", s, done_of(s)); end
        end
    endtask

    task automatic test_div();
        for (int s = 0; s < 2; s++) begin
            do_op(s, OP_DIVU, 32'd100, 32'd7, "divu");
            expect_val(s, 1'b0, 32'd14, "divu_q");
            expect_val(s, 1'b1, 32'd2, "divu_r");
            do_op(s, OP_DIV, -32'sd7, 32'd2, "div");
            expect_val(s, 1'b0, -32'sd3, "div_q");
            expect_val(s, 1'b1, -32'sd1, "div_r");
        end
    endtask

    task automatic test_div_special();
        logic [31:0] mn;
        for (int s = 0; s < 2; s++) begin
            mn = (s == 1) ? 32'h0000_8000 : 32'h8000_0000;
            do_op(s, OP_MTHI, 32'd5, 32'd0, "mthi");
            do_op(s, OP_MTLO, 32'd9, 32'd0, "mtlo");
            do_op(s, OP_DIV, 32'd1234, 32'd0, "div0");
            expect_val(s, 1'b1, 32'd5, "div0_hi");
            expect_val(s, 1'b0, 32'd9, "div0_lo");
            do_op(s, OP_DIV, mn, 32'hFFFF_FFFF, "divovf");
            expect_val(s, 1'b0, mn, "divovf_lo");
            expect_val(s, 1'b1, 32'd0, "divovf_hi");
        end
    endtask

    task automatic test_accum();
        for (int s = 0; s < 2; s++) begin
            do_op(s, OP_MTHI, 32'd0, 32'd0, "acc_mthi");
            do_op(s, OP_MTLO, 32'd10, 32'd0, "acc_mtlo");
            do_op(s, OP_MADDU, 32'd3, 32'd4, "maddu");
            expect_val(s, 1'b0, 32'd22, "maddu_lo");
            do_op(s, OP_MSUB, 32'd5, 32'd5, "msub");
            expect_val(s, 1'b1, 32'hFFFF_FFFF, "msub_hi");
            expect_val(s, 1'b0, 32'hFFFF_FFFD, "msub_lo");
        end
    endtask

    task automatic test_cancel();
        for (int s = 0; s < 2; s++) begin
            issue(s, OP_DIV, 32'd77, 32'd3);
            repeat (9) @(posedge clk);
            #1;
            checks++;
            if (busy_of(s) !== 1'b1) begin errors++; $display("FAIL cancel_pre w%0d busy: got %b want 1", s, busy_of(s)); end
            @(negedge clk) cancel = 1'b1;
            @(posedge clk); #1;
            cancel = 1'b0;
            checks++;
            if (busy_of(s) !== 1'b0 || done_of(s) !== 1'b0) begin
                errors++; $display("FAIL cancel w%0d busy/done: got %b%b want 00", s, busy_of(s), done_of(s));
            end
            check_hilo(s, "cancel");
            do_op(s, OP_MULTU, $urandom, $urandom, "after_cancel");
            @(negedge clk);
            op = OP_DIVU; a = 32'd50; b = 32'd5; start_v[s] = 1'b1; cancel = 1'b1;
            @(posedge clk); #1;
            start_v[s] = 1'b0; cancel = 1'b0;
            checks++;
            if (busy_of(s) !== 1'b0) begin errors++; $display("FAIL cancel_issue w%0d busy: got %b want 0", s, busy_of(s)); end
            check_hilo(s, "cancel_issue");
        end
    endtask

    task automatic test_reset_mid();
        issue(0, OP_DIVU, 32'd999, 32'd13);
        issue(1, OP_DIVU, 32'd999, 32'd13);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            m_hi[s] = '0; m_lo[s] = '0;
            checks++;
            if (busy_of(s) !== 1'b0) begin errors++; $display("FAIL reset_mid w%0d busy: got %b want 0", s, busy_of(s)); end
            check_hilo(s, "reset_mid");
        end
    endtask

    // start stays high (and op changes to MTHI) through the busy window: one MADDU only.
    task automatic test_back_to_back();
        int lat, n;
        for (int s = 0; s < 2; s++) begin
            do_op(s, OP_MTLO, 32'd100, 32'd0, "b2b_mtlo");
            lat = model_apply(s, OP_MADDU, 32'd6, 32'd7);
            @(negedge clk);
            op = OP_MADDU; a = 32'd6; b = 32'd7; start_v[s] = 1'b1;
            @(posedge clk); #1;
            op = OP_MTHI; a = 32'h1234_5678;
            n = 1;
            while (n < lat) begin @(posedge clk); #1; n++; end
            start_v[s] = 1'b0;
            checks++;
            if (busy_of(s) !== 1'b1) begin errors++; $display("FAIL b2b_busy w%0d: got %b want 1", s, busy_of(s)); end
            @(posedge clk); #1;
            checks++;
            if (busy_of(s) !== 1'b0 || done_of(s) !== 1'b1) begin
                errors++; $display("FAIL b2b_end w%0d busy/done: got %b%b want 01", s, busy_of(s), done_of(s));
            end
            check_hilo(s, "b2b");
        end
    endtask

    task automatic test_random();
        logic [3:0]  ops [15];
        logic [3:0]  o;
        logic [31:0] x, y;
        ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
                OP_MTHI, OP_MTLO, OP_NOP, 4'd11, 4'd15, OP_DIV, OP_MADD};
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 30; i++) begin
                o = ops[$urandom_range(0, 14)];
                x = $urandom;
                if ($urandom_range(0, 5) == 0) y = 32'd0;
                else if ($urandom_range(0, 1) == 1) y = $urandom;
                else y = 32'($urandom_range(1, 20));
                if ($urandom_range(0, 3) == 0) y = -y;
                do_op(s, o, x, y, "random");
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start_v = '0; op = OP_NOP; a = '0; b = '0;
        cancel = 1'b0; hilo_sel = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_div_special();
        test_accum();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
